// File: rtl/led_pulse_stretch.sv
// LED pulse stretcher: turns single-cycle event strobes into visible blinks of a fixed
// on-time, each followed by a fixed off-gap. Events that arrive during a blink are
// queued in a saturating counter. Events that overflow the counter raise a one-cycle
// dropped pulse.
module led_pulse_stretch #(
  parameter int unsigned N         = 19, // prescaler width; one tick = 2^N clk cycles
  parameter int unsigned ON_TICKS  = 3,  // blink on-time in ticks (>= 1)
  parameter int unsigned OFF_TICKS = 3,  // forced off-gap in ticks (>= 1)
  parameter int unsigned PEND_W    = 2   // pending-event counter width
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic evt_i,
  output logic led_o,
  output logic busy_o,
  output logic dropped_o
);

  localparam int unsigned MaxTicks = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  localparam logic [TickW-1:0]  OnLast  = TickW'(ON_TICKS - 1);
  localparam logic [TickW-1:0]  OffLast = TickW'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PendMax = '1;

  typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        presc_q, presc_d;
  logic [TickW-1:0]    tcnt_q, tcnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                dropped_q, dropped_d;

  logic tick;
  logic on_done;
  logic gap_done;
  logic pend_inc;
  logic pend_dec;
  logic state_entry;

  assign tick     = (presc_q == '1);
  assign on_done  = tick && (tcnt_q == OnLast);
  assign gap_done = tick && (tcnt_q == OffLast);

  // Next-state and pending-queue logic.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_inc  = 1'b0;
    pend_dec  = 1'b0;
    dropped_d = 1'b0;

    case (state_q)
      StIdle: begin
        // The event that starts a blink is consumed here and never queued.
        if (evt_i) state_d = StOn;
      end
      StOn: begin
        pend_inc = evt_i;
        if (on_done) state_d = StGap;
      end
      StGap: begin
        if (gap_done) begin
          if (pend_q != '0) begin
            state_d  = StOn;
            pend_dec = 1'b1;
            pend_inc = evt_i;
          end else if (evt_i) begin
            // Empty queue: a coincident event directly starts the next blink.
            state_d = StOn;
          end else begin
            state_d = StIdle;
          end
        end else begin
          pend_inc = evt_i;
        end
      end
      default: state_d = StIdle;
    endcase

    // A simultaneous increment and decrement leave the queue unchanged.
    if (pend_inc && !pend_dec) begin
      if (pend_q == PendMax) dropped_d = 1'b1;
      else                   pend_d    = pend_q + 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Phase timing: prescaler and tick counter restart on every state change.
  always_comb begin
    state_entry = (state_d != state_q);
    presc_d     = state_entry ? '0 : presc_q + 1'b1;
    tcnt_d      = tcnt_q;
    if (state_entry || (state_q == StIdle)) tcnt_d = '0;
    else if (tick)                          tcnt_d = tcnt_q + 1'b1;
    led_d  = (state_d == StOn);
    busy_d = (state_d != StIdle);
  end

  // State, timing and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      tcnt_q    <= '0;
      pend_q    <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tcnt_q    <= tcnt_d;
      pend_q    <= pend_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign led_o     = led_q;
  assign busy_o    = busy_q;
  assign dropped_o = dropped_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Bench for led_pulse_stretch: directed scenarios followed by random strobes, each cycle
// compared against a phase-countdown model of blink, gap and queue behaviour.
module tb_led_pulse_stretch;

  localparam int unsigned N         = 3;
  localparam int unsigned ON_TICKS  = 2;
  localparam int unsigned OFF_TICKS = 1;
  localparam int unsigned PEND_W    = 2;

  localparam int OnCyc   = ON_TICKS * (1 << N);
  localparam int GapCyc  = OFF_TICKS * (1 << N);
  localparam int PendMax = (1 << PEND_W) - 1;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic evt_i  = 1'b0;
  logic led_o;
  logic busy_o;
  logic dropped_o;

  led_pulse_stretch #(
    .N        (N),
    .ON_TICKS (ON_TICKS),
    .OFF_TICKS(OFF_TICKS),
    .PEND_W   (PEND_W)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .evt_i    (evt_i),
    .led_o    (led_o),
    .busy_o   (busy_o),
    .dropped_o(dropped_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 = idle, 1 = blink on, 2 = off-gap; m_left = cycles left in phase.
  int m_mode = 0;
  int m_left = 0;
  int m_pend = 0;
  bit m_drop = 1'b0;

  // Per-scenario observations.
  int   rises    = 0;
  int   busy_cnt = 0;
  logic led_prev = 1'b0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_left = 0;
    m_pend = 0;
    m_drop = 1'b0;
  endtask

  task automatic model_queue();
    if (m_pend < PendMax) m_pend++;
    else                  m_drop = 1'b1;
  endtask

  task automatic model_step(input bit e);
    m_drop = 1'b0;
    case (m_mode)
      0: begin
        if (e) begin
          m_mode = 1;
          m_left = OnCyc;
        end
      end
      1: begin
        if (e) model_queue();
        m_left--;
        if (m_left == 0) begin
          m_mode = 2;
          m_left = GapCyc;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (m_pend > 0) begin
            m_mode = 1;
            m_left = OnCyc;
            if (!e) m_pend--;
          end else if (e) begin
            m_mode = 1;
            m_left = OnCyc;
          end else begin
            m_mode = 0;
          end
        end else if (e) begin
          model_queue();
        end
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check_bit({tag, ".led"},     led_o,     m_mode == 1);
    check_bit({tag, ".busy"},    busy_o,    m_mode != 0);
    check_bit({tag, ".dropped"}, dropped_o, m_drop);
  endtask

  // One clock with the given strobe value; outputs sampled 1 time unit after the edge.
  task automatic cycle(input bit e, input string tag);
    evt_i = e;
    @(posedge clk_i);
    model_step(e);
    #1;
    check_outputs(tag);
    if (led_o && !led_prev) rises++;
    led_prev = led_o;
    if (busy_o) busy_cnt++;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, tag);
  endtask

  task automatic start_scenario();
    rises    = 0;
    busy_cnt = 0;
  endtask

  // Asynchronous reset asserted between edges, checked before any clock arrives.
  task automatic async_reset(input string tag);
    evt_i  = 1'b0;
    rst_ni = 1'b0;
    #2;
    model_reset();
    check_outputs(tag);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni   = 1'b1;
    led_prev = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(5, "post_reset");

    // 1: single event -> one 16-cycle blink, busy 24 cycles
    start_scenario();
    cycle(1'b1, "s1");
    idle(40, "s1");
    check_int("s1.blinks", rises, 1);
    check_int("s1.busy_cycles", busy_cnt, 24);

    // 2: event plus four more during ON; the last one is dropped
    start_scenario();
    cycle(1'b1, "s2");
    for (int i = 1; i <= 14; i++) cycle((i % 3) == 0, "s2");
    idle(110, "s2");
    check_int("s2.blinks", rises, 4);
    check_int("s2.busy_cycles", busy_cnt, 96);

    // 3: empty queue, event on the GAP exit edge restarts straight away
    start_scenario();
    cycle(1'b1, "s3");
    idle(23, "s3");
    cycle(1'b1, "s3.exit_evt");
    idle(40, "s3");
    check_int("s3.blinks", rises, 2);
    check_int("s3.busy_cycles", busy_cnt, 48);

    // 4: full queue, event coincident with GAP exit keeps the queue full, no drop
    start_scenario();
    cycle(1'b1, "s4");
    for (int i = 1; i <= 23; i++) cycle(i <= 3, "s4");
    cycle(1'b1, "s4.exit_evt");
    idle(120, "s4");
    check_int("s4.blinks", rises, 5);
    check_int("s4.busy_cycles", busy_cnt, 120);

    // 5: reset 5 cycles into ON with two events queued
    start_scenario();
    cycle(1'b1, "s5");
    cycle(1'b1, "s5");
    cycle(1'b1, "s5");
    idle(2, "s5");
    async_reset("s5.reset");
    start_scenario();
    idle(60, "s5.after");
    check_int("s5.blinks_after_reset", rises, 0);

    // 6: strobe held high 6 cycles -> 1 start, 3 queued, 2 dropped
    start_scenario();
    for (int i = 0; i < 6; i++) cycle(1'b1, "s6");
    idle(100, "s6");
    check_int("s6.blinks", rises, 4);
    check_int("s6.busy_cycles", busy_cnt, 96);

    // Random strobes with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 7, "rand");
      if (i == 1500) async_reset("rand.reset");
    end
    idle(150, "rand.drain");
    check_bit("rand.final_idle", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
